bsg_manycore_pod_array_reset_sequencer: RTL and testbench

- Per-pod reset distribution for an arbitrary num_pods_y_p x num_pods_x_p pod array.
- Generalises the fixed tag-to-dff-chain reset path with a programmable pipeline depth and per-column fan-out replication.
- Adds an optional staggered-release mode: pods leave reset one at a time, separated by a programmable gap, to bound inrush current and simultaneous boot traffic.
- Sits between the per-pod bsg_tag reset clients and the pod rows.

---
 rtl/bsg_manycore_pod_array_reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_bsg_manycore_pod_array_reset_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_pod_array_reset_sequencer.sv
// bsg_manycore_pod_array_reset_sequencer
//
// Distributes per-pod reset from the bsg_tag reset clients to the pod rows of
// a num_pods_y_p x num_pods_x_p pod array.
//
// Each pod has one "held" bit. A request asserts it on the next cycle
// unconditionally. Release happens in one of two ways:
//   - parallel  (stagger_en_i=0): every pending pod is released at once.
//   - staggered (stagger_en_i=1): the lowest-index pending pod is released,
//     then a gap of stagger_gap_p cycles passes before the next release.
//     Consecutive releases are stagger_gap_p+1 cycles apart.
// The held bits then pass through reset_depth_p-1 register stages. Every
// stage is replicated num_tiles_x_p wide per pod, one bit per tile column.
//
// Flat pod index f = y*num_pods_x_p + x.
//
// Handshake: there is no valid/ready handshake. pod_reset_req_i is a level
// and is sampled every cycle, and so is stagger_en_i. pod_reset_o is a level.
//
// Ports:
//   clk_i            clock
//   reset_i          synchronous active-high reset
//   stagger_en_i     1 = staggered release, 0 = parallel release
//   pod_reset_req_i  [y][x]       1 = hold that pod in reset
//   pod_reset_o      [y][x][tile] replicated per-pod reset to the pod rows
//   pod_in_reset_o   [y][x]       bit 0 of each pod's pod_reset_o
//   busy_o           a release is pending or a gap is being timed
//   dbg_state_o      debug view of the sequencer FSM (1 = GAP)

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_manycore_pod_array_reset_sequencer #(
  parameter int num_pods_x_p  = 1,
  parameter int num_pods_y_p  = 1,
  parameter int num_tiles_x_p = 16,
  parameter int reset_depth_p = 3,
  parameter int stagger_gap_p = 16
) (
  input  logic                                                       clk_i,
  input  logic                                                       reset_i,
  input  logic                                                       stagger_en_i,
  input  logic [num_pods_y_p-1:0][num_pods_x_p-1:0]                  pod_reset_req_i,
  output logic [num_pods_y_p-1:0][num_pods_x_p-1:0][num_tiles_x_p-1:0] pod_reset_o,
  output logic [num_pods_y_p-1:0][num_pods_x_p-1:0]                  pod_in_reset_o,
  output logic                                                       busy_o,
  output logic                                                       dbg_state_o
);

  localparam int num_pods_lp  = num_pods_y_p * num_pods_x_p;
  localparam int gap_width_lp = `BSG_SAFE_CLOG2(stagger_gap_p);
  localparam int stages_lp    = reset_depth_p - 1;
  localparam int rep_width_lp = num_pods_lp * num_tiles_x_p;

  localparam logic [gap_width_lp-1:0] gap_load_lp = gap_width_lp'(stagger_gap_p - 1);

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [gap_width_lp-1:0]   cnt_q, cnt_d;
  logic [num_pods_lp-1:0]    held_q, held_d;

  logic [num_pods_lp-1:0]    req_flat;
  logic [num_pods_lp-1:0]    pending;
  logic [num_pods_lp-1:0]    lowest_pending;
  logic [num_pods_lp-1:0]    release_mask;
  logic [rep_width_lp-1:0]   held_rep;
  logic [rep_width_lp-1:0]   out_flat;

  // The packed [y][x] request flattens so that bit f = y*num_pods_x_p + x.
  assign req_flat = pod_reset_req_i;
  assign pending  = held_q & ~req_flat;

  // Two's-complement trick isolates the lowest set bit of pending.
  assign lowest_pending = pending & (~pending + num_pods_lp'(1));

  // Release scheduling and gap timing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    release_mask = '0;

    if (!stagger_en_i) begin
      // Parallel mode also aborts any gap in progress.
      release_mask = pending;
      state_d      = IDLE;
      cnt_d        = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending) begin
            release_mask = lowest_pending;
            cnt_d        = gap_load_lp;
            state_d      = GAP;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - gap_width_lp'(1);
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // A request in the same cycle wins over any release aimed at that pod.
    held_d = (held_q & ~release_mask) | req_flat;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  // Fan each held bit out to one bit per tile column.
  always_comb begin
    held_rep = '0;
    for (int f = 0; f < num_pods_lp; f++) begin
      held_rep[f*num_tiles_x_p +: num_tiles_x_p] = {num_tiles_x_p{held_q[f]}};
    end
  end

  // Delay line. With reset_depth_p=1 the output is the replicated held bits.
  if (stages_lp == 0) begin : g_no_pipe
    assign out_flat = held_rep;
  end else begin : g_pipe
    logic [stages_lp-1:0][rep_width_lp-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = held_rep;
      for (int s = 1; s < stages_lp; s++) begin
        pipe_d[s] = pipe_q[s-1];
      end
    end

    // Reset fills every stage so a reset covers the full pipeline depth.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        pipe_q <= '1;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign out_flat = pipe_q[stages_lp-1];
  end

  assign pod_reset_o = out_flat;

  always_comb begin
    pod_in_reset_o = '0;
    for (int f = 0; f < num_pods_lp; f++) begin
      pod_in_reset_o[f/num_pods_x_p][f%num_pods_x_p] = out_flat[f*num_tiles_x_p];
    end
  end

  // Reports idle while reset is applied, even though every pod looks pending.
  assign busy_o      = ~reset_i & ((state_q == GAP) | (|pending));
  assign dbg_state_o = (state_q == GAP);

endmodule

// File: tb/tb_bsg_manycore_pod_array_reset_sequencer.sv
module tb_bsg_manycore_pod_array_reset_sequencer;

  localparam int NX = 2;
  localparam int NY = 2;
  localparam int T  = 4;
  localparam int G  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          reset_i;
  logic                          stagger_en_i;
  logic [NY-1:0][NX-1:0]         req;
  logic [NY-1:0][NX-1:0][T-1:0]  out3, out1;
  logic [NY-1:0][NX-1:0]         in3, in1;
  logic                          busy3, busy1, st3, st1;

  bsg_manycore_pod_array_reset_sequencer #(
    .num_pods_x_p(NX), .num_pods_y_p(NY), .num_tiles_x_p(T),
    .reset_depth_p(3), .stagger_gap_p(G)
  ) dut3 (
    .clk_i(clk), .reset_i(reset_i), .stagger_en_i(stagger_en_i),
    .pod_reset_req_i(req), .pod_reset_o(out3), .pod_in_reset_o(in3),
    .busy_o(busy3), .dbg_state_o(st3)
  );

  bsg_manycore_pod_array_reset_sequencer #(
    .num_pods_x_p(NX), .num_pods_y_p(NY), .num_tiles_x_p(T),
    .reset_depth_p(1), .stagger_gap_p(G)
  ) dut1 (
    .clk_i(clk), .reset_i(reset_i), .stagger_en_i(stagger_en_i),
    .pod_reset_req_i(req), .pod_reset_o(out1), .pod_in_reset_o(in1),
    .busy_o(busy1), .dbg_state_o(st1)
  );

  int checks   = 0;
  int failures = 0;
  // Entry: {state, busy, in_reset depth3 [3:0], in_reset depth1 [3:0]}
  logic [9:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rep4(input logic [3:0] v);
    logic [15:0] r;
    r = '0;
    for (int f = 0; f < 4; f++) r[f*4 +: 4] = {4{v[f]}};
    return r;
  endfunction

  // 1 when cycle r falls inside one of n gaps following releases at first+5k.
  function automatic logic in_gap(input int r, input int first, input int n);
    for (int k = 0; k < n; k++)
      if (r >= first + 5*k + 1 && r <= first + 5*k + 4) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs at cycle r of scenario scn (r=0 is the request-fall cycle).
  function automatic logic [9:0] expect_at(input int scn, input int r);
    logic [3:0] i3, i1;
    logic b, s;
    i3 = '1; i1 = '1; b = 1'b0; s = 1'b0;
    case (scn)
      1: begin
        i3 = (r >= 3) ? 4'h0 : 4'hF;
        i1 = (r >= 1) ? 4'h0 : 4'hF;
        b  = (r == 0);
      end
      2: begin
        i3[0] = (r < 3) || (r >= 5 && r < 23);
        i1[0] = (r < 1) || (r >= 3 && r < 21);
        for (int k = 1; k < 4; k++) begin
          i3[k] = (r < 5*k + 3);
          i1[k] = (r < 5*k + 1);
        end
        b = (r <= 24);
        s = in_gap(r, 0, 5);
      end
      3: begin
        i3[0] = (r < 3); i1[0] = (r < 1);
        i3[1] = (r < 8); i1[1] = (r < 6);
        for (int k = 2; k < 4; k++) begin
          i3[k] = (r < 9); i1[k] = (r < 7);
        end
        b = (r <= 6);
        s = (r >= 1 && r <= 4) || (r == 6);
      end
      4: begin
        if (r <= 10) begin
          i3[0] = (r < 3); i1[0] = (r < 1);
          i3[1] = (r < 8); i1[1] = (r < 6);
          b = (r < 10);
          s = in_gap(r, 0, 2);
        end else begin
          for (int k = 0; k < 4; k++) begin
            i3[k] = (r < 11 + 5*k + 3);
            i1[k] = (r < 11 + 5*k + 1);
          end
          b = (r <= 30);
          s = in_gap(r, 11, 4);
        end
      end
      default: ;
    endcase
    return {s, b, i3, i1};
  endfunction

  task automatic cycle(input logic [9:0] e);
    logic [9:0] x;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    check_val("state3",   st3,   x[9]);
    check_val("busy3",    busy3, x[8]);
    check_val("in_rst3",  in3,   x[7:4]);
    check_val("pod_rst3", out3,  rep4(x[7:4]));
    check_val("busy1",    busy1, x[8]);
    check_val("in_rst1",  in1,   x[3:0]);
    check_val("pod_rst1", out1,  rep4(x[3:0]));
    @(posedge clk);
    #1;
  endtask

  // Reset with all requests high, then one quiet cycle out of reset.
  task automatic prelude();
    reset_i = 1'b1; stagger_en_i = 1'b0; req = '1;
    @(posedge clk);
    #1;
    cycle(10'b00_1111_1111);
    cycle(10'b00_1111_1111);
    reset_i = 1'b0;
    cycle(10'b00_1111_1111);
  endtask

  task automatic run_scn(input int scn, input int len);
    for (int r = 0; r < len; r++) begin
      reset_i      = (scn == 4 && r == 10);
      stagger_en_i = (scn == 1) ? 1'b0 : (scn == 3) ? (r < 6) : 1'b1;
      req          = '0;
      req[0][0]    = (scn == 2 && r >= 2 && r <= 16);
      cycle(expect_at(scn, r));
    end
  endtask

  initial begin
    reset_i = 1'b1; stagger_en_i = 1'b0; req = '1;
    prelude(); run_scn(1, 6);
    prelude(); run_scn(2, 28);
    prelude(); run_scn(3, 11);
    prelude(); run_scn(4, 33);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected count=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
